// File: rtl/decimal_to_binary_encoder_pkg.sv
// Shared types and constants for the one-hot decimal to binary encoder.
package dec_enc_pkg;

    localparam int DIGITS = 10;
    localparam int CODE_W = 4;

    typedef logic [DIGITS-1:0] dec_onehot_t;
    typedef logic [CODE_W-1:0] bin_code_t;

    localparam bin_code_t INVALID_CODE_DEFAULT = 4'hF;

endpackage

// File: rtl/decimal_to_binary_encoder_onehot_classifier.sv
// Combinational decode of a one-hot decimal digit: OR-encoded index, highest
// set index, zero/multi-hot detection and whether the code can be encoded.
module onehot_classifier
    import dec_enc_pkg::*;
(
    input  dec_onehot_t decimal_input,
    input  logic        priority_mode,
    output bin_code_t   index,
    output bin_code_t   high_index,
    output logic        is_zero,
    output logic        is_multi,
    output logic        encodable
);

    always_comb begin
        // NOTE: every output of this block is assigned a default first, so no
        // path through the loop can leave one unassigned and infer a latch.
        index      = '0;
        high_index = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (decimal_input[i]) begin
                index      = index | bin_code_t'(i);
                high_index = bin_code_t'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something behind only if popcount > 1.
    assign is_zero   = (decimal_input == '0);
    assign is_multi  = ((decimal_input & (decimal_input - dec_onehot_t'(1))) != '0);
    assign encodable = !is_zero && (!is_multi || priority_mode);

endmodule

// File: rtl/decimal_to_binary_encoder.sv
// Registered one-hot decimal to 4-bit binary encoder with per-sample error
// flags and a saturating count of malformed samples.
module decimal_to_binary_encoder
    import dec_enc_pkg::*;
#(
    parameter int        PRIORITY_MODE = 0,
    parameter int        CNT_W         = 8,
    parameter bin_code_t INVALID_CODE  = INVALID_CODE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [9:0]       decimal_input,
    output logic [3:0]       binary_output,
    output logic             out_valid,
    output logic             err_none,
    output logic             err_multi,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    bin_code_t index;
    bin_code_t high_index;
    logic      is_zero;
    logic      is_multi;
    logic      encodable;
    bin_code_t next_code;

    onehot_classifier u_classifier (
        .decimal_input (decimal_input),
        .priority_mode (PRIORITY_MODE != 0),
        .index         (index),
        .high_index    (high_index),
        .is_zero       (is_zero),
        .is_multi      (is_multi),
        .encodable     (encodable)
    );

    // A multi-hot code only reaches here as encodable in priority mode.
    assign next_code = !encodable ? INVALID_CODE :
                       is_multi   ? high_index   : index;

    // NOTE: state is updated with non-blocking assignments and the reset is in
    // the sensitivity list, so it clears the outputs without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            binary_output <= '0;
            out_valid     <= 1'b0;
            err_none      <= 1'b0;
            err_multi     <= 1'b0;
            err_count     <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                binary_output <= next_code;
                err_none      <= is_zero;
                err_multi     <= is_multi;
                if ((is_zero || is_multi) && (err_count != CNT_MAX))
                    err_count <= err_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_decimal_to_binary_encoder.sv
// Directed bench: strict-mode/8-bit-counter and priority-mode/2-bit-counter
// encoders driven from one shared stimulus table.
module tb_decimal_to_binary_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [9:0] decimal_input = '0;

    logic [3:0] bin0, bin1;
    logic       ov0, ov1, none0, none1, multi0, multi1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decimal_to_binary_encoder #(.PRIORITY_MODE(0), .CNT_W(8)) dut_strict (
        .clk(clk), .rst(rst), .in_valid(in_valid), .decimal_input(decimal_input),
        .binary_output(bin0), .out_valid(ov0), .err_none(none0),
        .err_multi(multi0), .err_count(cnt0)
    );

    decimal_to_binary_encoder #(.PRIORITY_MODE(1), .CNT_W(2)) dut_prio (
        .clk(clk), .rst(rst), .in_valid(in_valid), .decimal_input(decimal_input),
        .binary_output(bin1), .out_valid(ov1), .err_none(none1),
        .err_multi(multi1), .err_count(cnt1)
    );

    typedef struct {
        logic       v;
        logic [9:0] din;
        logic [3:0] b0;
        logic [3:0] b1;
        logic       none;
        logic       multi;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [9:0] din, input logic [3:0] b0,
                       input logic [3:0] b1, input logic none, input logic multi);
        vec_t e;
        e.v = v; e.din = din; e.b0 = b0; e.b1 = b1; e.none = none; e.multi = multi;
        vecs.push_back(e);
    endtask

    task automatic check_all(input string tag, input logic [3:0] b0, input logic [3:0] b1,
                             input logic ov, input logic none, input logic multi,
                             input int c0, input int c1);
        check({tag, " bin_strict"}, 32'(bin0), 32'(b0));
        check({tag, " bin_prio"},   32'(bin1), 32'(b1));
        check({tag, " valid_strict"}, 32'(ov0), 32'(ov));
        check({tag, " valid_prio"},   32'(ov1), 32'(ov));
        check({tag, " none_strict"},  32'(none0), 32'(none));
        check({tag, " none_prio"},    32'(none1), 32'(none));
        check({tag, " multi_strict"}, 32'(multi0), 32'(multi));
        check({tag, " multi_prio"},   32'(multi1), 32'(multi));
        check({tag, " cnt_strict"},   32'(cnt0), 32'(c0));
        check({tag, " cnt_prio"},     32'(cnt1), 32'(c1));
    endtask

    initial begin
        int exp_c0 = 0;
        int exp_c1 = 0;

        for (int i = 0; i < 10; i++) add(1'b1, 10'(1) << i, 4'(i), 4'(i), 1'b0, 1'b0);
        add(1'b1, 10'b0000000000, 4'hF, 4'hF, 1'b1, 1'b0);
        add(1'b1, 10'b0000100100, 4'hF, 4'h5, 1'b0, 1'b1);
        add(1'b1, 10'b0010000000, 4'h7, 4'h7, 1'b0, 1'b0);
        add(1'b0, 10'b0000000011, 4'h7, 4'h7, 1'b0, 1'b0);
        add(1'b1, 10'b1000000001, 4'hF, 4'h9, 1'b0, 1'b1);
        add(1'b0, 10'b0000000000, 4'hF, 4'h9, 1'b0, 1'b1);
        add(1'b1, 10'b1111111111, 4'hF, 4'h9, 1'b0, 1'b1);
        add(1'b1, 10'b0000000000, 4'hF, 4'hF, 1'b1, 1'b0);
        add(1'b1, 10'b0000001000, 4'h3, 4'h3, 1'b0, 1'b0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0);

        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid      = vecs[i].v;
            decimal_input = vecs[i].din;
            @(posedge clk);
            #1;
            if (vecs[i].v && (vecs[i].none || vecs[i].multi)) begin
                if (exp_c0 < 255) exp_c0++;
                if (exp_c1 < 3)   exp_c1++;
            end
            check_all($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].v,
                      vecs[i].none, vecs[i].multi, exp_c0, exp_c1);
        end

        // Asynchronous reset between edges clears everything immediately.
        @(negedge clk);
        in_valid      = 1'b1;
        decimal_input = 10'b0000000000;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0);
        @(posedge clk);
        #1;
        check_all("rst_held", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0);

        // First sample after reset release.
        @(negedge clk);
        rst           = 1'b0;
        decimal_input = 10'b1000000000;
        @(posedge clk);
        #1;
        check_all("post_rst", 4'h9, 4'h9, 1'b1, 1'b0, 1'b0, 0, 0);

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_idle", 4'h9, 4'h9, 1'b0, 1'b0, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
